// File: rtl/seq_pattern_gen.sv
// Table-driven pattern sequencer with hold, one-shot, loop and ping-pong stepping.
// All state updates on the falling edge of clk. Reset is synchronous and active-high.
module seq_pattern_gen #(
  parameter int unsigned      WIDTH = 3,
  parameter int unsigned      DEPTH = 8,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(3'b101),
  localparam int unsigned     AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    last_idx,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic [AW-1:0]    idx,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'b00,
    MODE_ONESHOT  = 2'b01,
    MODE_LOOP     = 2'b10,
    MODE_PINGPONG = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [WIDTH-1:0] table_q [DEPTH];
  logic [WIDTH-1:0] q_q, q_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  dir_e             dir_q, dir_d;
  logic             load_c;

  // Pattern table storage; not reset, writable at any time.
  always_ff @(negedge clk) begin
    if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  // Control and output registers.
  always_ff @(negedge clk) begin
    if (rst) begin
      q_q    <= INIT;
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      dir_q  <= DIR_UP;
    end else begin
      q_q    <= q_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      wrap_q <= wrap_d;
      dir_q  <= dir_d;
    end
  end

  // Next-state: stop > start > step; q reloads from the pre-write table contents.
  always_comb begin
    idx_d  = idx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    wrap_d = 1'b0;
    dir_d  = dir_q;
    load_c = 1'b0;

    if (stop) begin
      busy_d = 1'b0;
    end else if (start) begin
      idx_d  = '0;
      busy_d = 1'b1;
      dir_d  = DIR_UP;
      load_c = 1'b1;
    end else if (busy_q) begin
      unique case (mode_e'(mode))
        MODE_HOLD: begin
          busy_d = 1'b1;
        end
        MODE_ONESHOT: begin
          if (idx_q < last_idx) begin
            idx_d  = AW'(idx_q + AW'(1));
            load_c = 1'b1;
          end else begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
        MODE_LOOP: begin
          load_c = 1'b1;
          if (idx_q < last_idx) begin
            idx_d = AW'(idx_q + AW'(1));
          end else begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end
        end
        MODE_PINGPONG: begin
          load_c = 1'b1;
          if (last_idx == '0 && idx_q == '0) begin
            // Degenerate one-entry table: sit at 0 and wrap every step.
            idx_d  = '0;
            dir_d  = DIR_UP;
            wrap_d = 1'b1;
          end else if (dir_q == DIR_UP) begin
            if (idx_q < last_idx) begin
              idx_d = AW'(idx_q + AW'(1));
            end else begin
              dir_d = DIR_DOWN;
              idx_d = AW'(idx_q - AW'(1));
            end
          end else begin
            if (idx_q != '0) begin
              idx_d = AW'(idx_q - AW'(1));
            end else begin
              dir_d  = DIR_UP;
              idx_d  = AW'(1);
              wrap_d = 1'b1;
            end
          end
        end
        default: begin
          busy_d = busy_q;
        end
      endcase
    end

    q_d = load_c ? table_q[idx_d] : q_q;
  end

  assign q    = q_q;
  assign idx  = idx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen; inputs change and outputs are sampled 1ns after each falling edge.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [2:0] wr_data;
  logic [2:0] last_idx;
  logic [1:0] mode;
  logic       start;
  logic       stop;
  logic [2:0] q;
  logic [2:0] idx;
  logic       busy;
  logic       done;
  logic       wrap;

  int n_vec = 0;
  int n_err = 0;

  seq_pattern_gen dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .last_idx (last_idx),
    .mode     (mode),
    .start    (start),
    .stop     (stop),
    .q        (q),
    .idx      (idx),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare all outputs at once as {q, idx, busy, done, wrap}.
  task automatic check_all(input string tag, input logic [2:0] eq, input logic [2:0] ei,
                           input logic eb, input logic ed, input logic ew);
    check(tag, 32'({q, idx, busy, done, wrap}), 32'({eq, ei, eb, ed, ew}));
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int pp_idx  [9] = '{1, 2, 1, 0, 1, 2, 1, 0, 1};
  int pp_wrap [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    last_idx = '0; mode = 2'b00; start = 1'b0; stop = 1'b0;
    tick();
    check_all("reset", 3'b101, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all("reset_idle", 3'b101, 3'd0, 1'b0, 1'b0, 1'b0);
    end

    // Fill table with 7..0.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 3'(7 - i);
      tick();
    end
    wr_en = 1'b0;
    check_all("idle_after_writes", 3'b101, 3'd0, 1'b0, 1'b0, 1'b0);

    // Loop over 4 entries.
    mode = 2'b10; last_idx = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check_all("loop_start", 3'd7, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_all("loop_step", 3'(7 - (i % 4)), 3'(i % 4), 1'b1, 1'b0, (i % 4) == 0);
    end

    // Control priority: stop beats start, then start restarts.
    tick();
    check_all("loop_pre_stop", 3'd6, 3'd1, 1'b1, 1'b0, 1'b0);
    stop = 1'b1; start = 1'b1;
    tick();
    check_all("stop_and_start", 3'd6, 3'd1, 1'b0, 1'b0, 1'b0);
    stop = 1'b0; start = 1'b0;
    tick();
    check_all("stopped_hold", 3'd6, 3'd1, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_all("restart", 3'd7, 3'd0, 1'b1, 1'b0, 1'b0);

    // Hold mode keeps position while busy.
    mode = 2'b00;
    tick();
    check_all("hold", 3'd7, 3'd0, 1'b1, 1'b0, 1'b0);

    // Ping-pong over indices 0..2.
    mode = 2'b11; last_idx = 3'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check_all("pp_start", 3'd7, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check_all("pp_step", 3'(7 - pp_idx[i]), 3'(pp_idx[i]), 1'b1, 1'b0, 1'(pp_wrap[i]));
    end

    // One-shot over indices 0..2.
    mode = 2'b01; last_idx = 3'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check_all("os_start", 3'd7, 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("os_step1", 3'd6, 3'd1, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("os_step2", 3'd5, 3'd2, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("os_done", 3'd5, 3'd2, 1'b0, 1'b1, 1'b0);
    tick();
    check_all("os_after", 3'd5, 3'd2, 1'b0, 1'b0, 1'b0);

    // Reset mid-run overrides a simultaneous start.
    mode = 2'b10; last_idx = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_all("pre_rst", 3'd6, 3'd1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check_all("rst_midrun", 3'b101, 3'd0, 1'b0, 1'b0, 1'b0);

    // Write collision with the load of index 0.
    mode = 2'b10; last_idx = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check_all("col_start", 3'd7, 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("col_idx1", 3'd6, 3'd1, 1'b1, 1'b0, 1'b0);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 3'b010;
    tick();
    wr_en = 1'b0;
    check_all("col_old_value", 3'd7, 3'd0, 1'b1, 1'b0, 1'b1);
    tick();
    check_all("col_idx1b", 3'd6, 3'd1, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("col_new_value", 3'd2, 3'd0, 1'b1, 1'b0, 1'b1);

    // last_idx == 0: loop wraps every step at index 0.
    last_idx = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check_all("l0_start", 3'd2, 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("l0_wrap1", 3'd2, 3'd0, 1'b1, 1'b0, 1'b1);
    tick();
    check_all("l0_wrap2", 3'd2, 3'd0, 1'b1, 1'b0, 1'b1);

    // last_idx == 0: one-shot completes on the first step.
    mode = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_all("l0_os_done", 3'd2, 3'd0, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
